jesd_tx_link_ctrl: RTL and testbench

JESD_TX_LINK_CTRL -- requirements
Module: jesd_tx_link_ctrl

---
 rtl/jesd_tx_pkg.sv | 40 ++++
 rtl/jesd_tx_sync_mon.sv | 61 ++++++
 rtl/jesd_tx_link_ctrl.sv | 109 ++++++++++
 tb/tb_jesd_tx_link_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_tx_pkg.sv
// Shared codes and helpers for the JESD204 transmit link controller.
package jesd_tx_pkg;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILA  = 2'd1,
        ST_DATA = 2'd2
    } link_state_t;

    localparam logic [1:0] MUX_USER  = 2'd0;
    localparam logic [1:0] MUX_KCHAR = 2'd1;
    localparam logic [1:0] MUX_ILA   = 2'd2;
    localparam logic [1:0] MUX_IDLE  = 2'd3;

    // Minimum /K/ frames before ILA may start; argument is F-1 as carried on the config bus.
    function automatic logic [3:0] k_min(input logic [7:0] f_minus1);
        logic [8:0] f;
        f = {1'b0, f_minus1} + 9'd1;
        if (f == 9'd1)
            return 4'd10;
        else if (f == 9'd2)
            return 4'd6;
        else if (f <= 9'd4)
            return 4'd4;
        else if (f <= 9'd8)
            return 4'd3;
        else
            return 4'd2;
    endfunction

    function automatic logic [1:0] state_mux(input link_state_t s);
        case (s)
            ST_CGS:  return MUX_KCHAR;
            ST_ILA:  return MUX_ILA;
            ST_DATA: return MUX_USER;
            default: return MUX_KCHAR;
        endcase
    endfunction

endpackage

// File: rtl/jesd_tx_sync_mon.sv
// SYNC~ monitor for the DATA phase: counts consecutive low frames, flags short drops.
module jesd_tx_sync_mon #(
    parameter int REINIT_FRAMES = 5,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 frame_tick,
    input  logic                 sync_n,
    output logic                 reinit,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [3:0] REINIT_LAST = 4'(REINIT_FRAMES - 1);

    logic [3:0]           low_cnt_reg, low_cnt_next;
    logic                 err_next;
    logic                 sync_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    always_comb begin
        low_cnt_next = low_cnt_reg;
        err_next     = 1'b0;
        reinit       = 1'b0;
        if (!en) begin
            low_cnt_next = '0;
        end else if (frame_tick) begin
            if (!sync_n) begin
                if (low_cnt_reg == REINIT_LAST) begin
                    reinit       = 1'b1;
                    low_cnt_next = '0;
                end else begin
                    low_cnt_next = low_cnt_reg + 4'd1;
                end
            end else begin
                // The count never rests at REINIT_FRAMES, so any non-zero run is a short drop.
                err_next     = (low_cnt_reg != 4'd0);
                low_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_reg  <= '0;
            sync_err_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            low_cnt_reg  <= low_cnt_next;
            sync_err_reg <= err_next;
            if (err_next && err_cnt_reg != {ERR_CNT_W{1'b1}})
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign sync_err = sync_err_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204 transmit link controller: CGS -> ILA -> DATA sequencing and per-lane source select.
module jesd_tx_link_ctrl
    import jesd_tx_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int REINIT_FRAMES = 5,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_frame_tick,
    input  logic                   i_lmfc_tick,
    input  logic                   i_sync_n,
    input  logic [7:0]             i_F,
    input  logic [7:0]             i_ila_mf_len,
    input  logic [NUM_LANES-1:0]   i_lane_en,
    input  logic                   i_force_cgs,
    output logic [2*NUM_LANES-1:0] o_link_mux,
    output logic [1:0]             o_state,
    output logic [7:0]             o_ila_mf_idx,
    output logic                   o_sync_err,
    output logic [ERR_CNT_W-1:0]   o_err_cnt
);

    link_state_t            state_reg, state_next;
    logic [3:0]             frame_cnt_reg, frame_cnt_next;
    logic [8:0]             mf_cnt_reg, mf_cnt_next;
    logic [7:0]             mf_len_reg;
    logic [2*NUM_LANES-1:0] mux_reg, mux_next;
    logic [3:0]             kmin;
    logic                   reinit;

    assign kmin = k_min(i_F);

    jesd_tx_sync_mon #(
        .REINIT_FRAMES (REINIT_FRAMES),
        .ERR_CNT_W     (ERR_CNT_W)
    ) u_sync_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_reg == ST_DATA),
        .frame_tick (i_frame_tick),
        .sync_n     (i_sync_n),
        .reinit     (reinit),
        .sync_err   (o_sync_err),
        .err_cnt    (o_err_cnt)
    );

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        mf_cnt_next    = mf_cnt_reg;
        case (state_reg)
            ST_CGS: begin
                if (i_frame_tick && frame_cnt_reg != 4'hF)
                    frame_cnt_next = frame_cnt_reg + 4'd1;
                if (i_lmfc_tick && i_sync_n && !i_force_cgs && frame_cnt_reg >= kmin)
                    state_next = ST_ILA;
            end
            ST_ILA: begin
                if (i_lmfc_tick)
                    mf_cnt_next = mf_cnt_reg + 9'd1;
                if (!i_sync_n || i_force_cgs)
                    state_next = ST_CGS;
                else if (i_lmfc_tick && mf_cnt_reg == {1'b0, mf_len_reg})
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (i_force_cgs || reinit)
                    state_next = ST_CGS;
            end
            default: state_next = ST_CGS;
        endcase
        // Counters only live inside their own state, so every entry starts from zero.
        if (state_reg != ST_CGS || state_next != ST_CGS)
            frame_cnt_next = '0;
        if (state_next != ST_ILA)
            mf_cnt_next = '0;
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_mux
            assign mux_next[2*gi +: 2] = i_lane_en[gi] ? state_mux(state_next) : MUX_IDLE;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_CGS;
            frame_cnt_reg <= '0;
            mf_cnt_reg    <= '0;
            mf_len_reg    <= '0;
            mux_reg       <= {NUM_LANES{MUX_KCHAR}};
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            mf_cnt_reg    <= mf_cnt_next;
            mux_reg       <= mux_next;
            // ILA length is frozen while the link is up and reloaded only in CGS.
            if (state_reg == ST_CGS)
                mf_len_reg <= i_ila_mf_len;
        end
    end

    assign o_state      = state_reg;
    assign o_link_mux   = mux_reg;
    assign o_ila_mf_idx = mf_cnt_reg[7:0];

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Self-checking bench for jesd_tx_link_ctrl: vector table, directed corner sequences, random run vs reference model.
module tb_jesd_tx_link_ctrl;

    localparam int NL = 4;
    localparam int RF = 5;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ft = 1'b0, lt = 1'b0, sn = 1'b1, fc = 1'b0;
    logic [7:0]    cfg_f = 8'd0, cfg_len = 8'd3;
    logic [NL-1:0] lane_en = '1;

    logic [2*NL-1:0] o_link_mux;
    logic [1:0]      o_state;
    logic [7:0]      o_ila_mf_idx;
    logic            o_sync_err;
    logic [EW-1:0]   o_err_cnt;

    always #5 clk = ~clk;

    jesd_tx_link_ctrl #(.NUM_LANES(NL), .REINIT_FRAMES(RF), .ERR_CNT_W(EW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (ft),
        .i_lmfc_tick  (lt),
        .i_sync_n     (sn),
        .i_F          (cfg_f),
        .i_ila_mf_len (cfg_len),
        .i_lane_en    (lane_en),
        .i_force_cgs  (fc),
        .o_link_mux   (o_link_mux),
        .o_state      (o_state),
        .o_ila_mf_idx (o_ila_mf_idx),
        .o_sync_err   (o_sync_err),
        .o_err_cnt    (o_err_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame_idx = 0;
    int fp = 2;
    int mfp = 4;
    int pulses_seen = 0;

    // Reference model: link phase 0=CGS 1=ILA 2=DATA plus the spec's counters.
    int              m_state, m_frames, m_mf, m_low, m_err, m_len;
    bit              m_pulse;
    logic [2*NL-1:0] m_mux;

    typedef struct {
        logic [7:0]      f;
        logic [NL-1:0]   en;
        int              frames;
        logic [2*NL-1:0] mux;
    } vec_t;
    vec_t vecs[8];

    function automatic int kmin_of(input int octets);
        if (octets == 1) return 10;
        if (octets == 2) return 6;
        if (octets <= 4) return 4;
        if (octets <= 8) return 3;
        return 2;
    endfunction

    function automatic logic [2*NL-1:0] exp_mux(input int st, input logic [NL-1:0] en);
        logic [2*NL-1:0] r;
        int code;
        code = (st == 0) ? 1 : (st == 1) ? 2 : 0;
        for (int l = 0; l < NL; l++)
            r[2*l +: 2] = en[l] ? 2'(code) : 2'd3;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_frames = 0; m_mf = 0; m_low = 0; m_err = 0; m_len = 0;
        m_pulse = 0;
        m_mux = {NL{2'b01}};
    endtask

    task automatic model_edge();
        int  ns;
        int  kmin;
        bit  pulse;
        pulse = 0;
        kmin  = kmin_of(int'(cfg_f) + 1);
        ns    = m_state;
        if (m_state == 0) begin
            m_len = int'(cfg_len);
            if (lt && sn && !fc && m_frames >= kmin) ns = 1;
            if (ft && m_frames < 15) m_frames++;
        end else if (m_state == 1) begin
            if (!sn || fc) ns = 0;
            else if (lt && m_mf == m_len) ns = 2;
            if (lt) m_mf++;
        end else begin
            if (fc) ns = 0;
            if (ft) begin
                if (!sn) begin
                    m_low++;
                    if (m_low == RF) ns = 0;
                end else begin
                    if (m_low > 0) pulse = 1;
                    m_low = 0;
                end
            end
        end
        if (ns != 0 || m_state != 0) m_frames = 0;
        if (ns != 1) m_mf = 0;
        if (ns != 2) m_low = 0;
        if (pulse && m_err < (1 << EW) - 1) m_err++;
        m_pulse = pulse;
        m_state = ns;
        m_mux   = exp_mux(ns, lane_en);
    endtask

    task automatic step(input bit t_ft, input bit t_lt, input bit t_sn, input bit t_fc);
        ft = t_ft; lt = t_lt; sn = t_sn; fc = t_fc;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("state",    int'(o_state),      m_state);
        chk("mux",      int'(o_link_mux),   int'(m_mux));
        chk("mf_idx",   int'(o_ila_mf_idx), m_mf & 255);
        chk("sync_err", int'(o_sync_err),   int'(m_pulse));
        chk("err_cnt",  int'(o_err_cnt),    m_err);
        if (o_sync_err) pulses_seen++;
        ft = 1'b0; lt = 1'b0;
    endtask

    task automatic frame(input bit t_sn, input bit t_fc);
        step(1'b1, (frame_idx % mfp) == 0, t_sn, t_fc);
        frame_idx++;
        for (int c = 1; c < fp; c++) step(1'b0, 1'b0, t_sn, t_fc);
    endtask

    task automatic do_reset();
        ft = 1'b0; lt = 1'b0; fc = 1'b0; sn = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("rst_state",   int'(o_state),      0);
        chk("rst_mux",     int'(o_link_mux),   8'h55);
        chk("rst_mf_idx",  int'(o_ila_mf_idx), 0);
        chk("rst_err",     int'(o_sync_err),   0);
        chk("rst_err_cnt", int'(o_err_cnt),    0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_idx = 0;
    endtask

    task automatic go_to(input int target);
        for (int n = 0; n < 200 && int'(o_state) != target; n++) frame(1'b1, 1'b0);
        chk("reach_state", int'(o_state), target);
    endtask

    initial begin
        int n;
        int low_left;

        vecs[0] = '{f: 8'd0,   en: 4'b1111, frames: 11, mux: 8'hAA};
        vecs[1] = '{f: 8'd1,   en: 4'b0001, frames: 7,  mux: 8'hFE};
        vecs[2] = '{f: 8'd2,   en: 4'b1000, frames: 5,  mux: 8'hBF};
        vecs[3] = '{f: 8'd3,   en: 4'b0110, frames: 5,  mux: 8'hEB};
        vecs[4] = '{f: 8'd4,   en: 4'b1111, frames: 4,  mux: 8'hAA};
        vecs[5] = '{f: 8'd7,   en: 4'b0000, frames: 4,  mux: 8'hFF};
        vecs[6] = '{f: 8'd8,   en: 4'b1111, frames: 3,  mux: 8'hAA};
        vecs[7] = '{f: 8'd200, en: 4'b0101, frames: 3,  mux: 8'hEE};

        #1;
        // k_min table: LMFC on every frame, so ILA starts on frame index k_min.
        fp = 2; mfp = 1;
        for (int v = 0; v < 8; v++) begin
            cfg_f = vecs[v].f; lane_en = vecs[v].en; cfg_len = 8'd0;
            do_reset();
            n = 0;
            while (n < 40 && int'(o_state) != 1) begin
                frame(1'b1, 1'b0);
                n++;
            end
            chk($sformatf("kmin_frames_v%0d", v), n, vecs[v].frames);
            chk($sformatf("ila_mux_v%0d", v), int'(o_link_mux), int'(vecs[v].mux));
        end

        // ILA entry with F=1 octet and 4-frame multiframes.
        fp = 2; mfp = 4; cfg_f = 8'd0; cfg_len = 8'd3; lane_en = '1;
        do_reset();
        n = 0;
        while (n < 40 && int'(o_state) != 1) begin
            frame(1'b1, 1'b0);
            n++;
        end
        chk("ila_entry_frames", n, 13);
        chk("ila_mux", int'(o_link_mux), 8'hAA);

        // Four multiframes of ILA, index walking 0..3, then DATA.
        for (int m = 0; m < 4; m++) begin
            chk("ila_idx", int'(o_ila_mf_idx), m);
            chk("ila_hold", int'(o_state), 1);
            for (int k = 0; k < 4; k++) frame(1'b1, 1'b0);
        end
        chk("data_entry", int'(o_state), 2);
        chk("data_mux", int'(o_link_mux), 8'h00);

        // Short SYNC~ drop: one error pulse, link stays up.
        pulses_seen = 0;
        for (int k = 0; k < 3; k++) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        chk("short_pulses", pulses_seen, 1);
        chk("short_err_cnt", int'(o_err_cnt), 1);
        chk("short_state", int'(o_state), 2);

        // Long SYNC~ drop: re-init on the fifth low frame, no error pulse.
        pulses_seen = 0;
        for (int k = 0; k < 4; k++) frame(1'b0, 1'b0);
        chk("long_still_data", int'(o_state), 2);
        frame(1'b0, 1'b0);
        chk("long_state", int'(o_state), 0);
        chk("long_mux", int'(o_link_mux), 8'h55);
        chk("long_pulses", pulses_seen, 0);

        // Lane masking and error counter saturation.
        go_to(2);
        lane_en = 4'b0101;
        frame(1'b1, 1'b0);
        chk("lane_mask_mux", int'(o_link_mux), 8'hCC);
        for (int k = 0; k < 256; k++) begin
            frame(1'b0, 1'b0);
            frame(1'b1, 1'b0);
        end
        chk("err_cnt_sat", int'(o_err_cnt), 255);
        chk("sat_state", int'(o_state), 2);

        // Reset asserted mid-ILA, away from the clock edge.
        lane_en = '1;
        do_reset();
        go_to(1);
        for (int k = 0; k < 5; k++) frame(1'b1, 1'b0);
        chk("pre_rst_idx", int'(o_ila_mf_idx), 1);
        #2;
        do_reset();

        // Randomised traffic against the reference model.
        for (int r = 0; r < 4; r++) begin
            fp = $urandom_range(1, 3);
            mfp = $urandom_range(1, 4);
            cfg_f = 8'($urandom_range(0, 12));
            cfg_len = 8'($urandom_range(0, 3));
            lane_en = NL'($urandom);
            do_reset();
            low_left = 0;
            for (int k = 0; k < 600; k++) begin
                bit fr_sn;
                bit fr_fc;
                if (low_left > 0) begin
                    fr_sn = 1'b0;
                    low_left--;
                end else if ($urandom_range(0, 19) == 0) begin
                    low_left = $urandom_range(0, 5);
                    fr_sn = 1'b0;
                end else begin
                    fr_sn = 1'b1;
                end
                fr_fc = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 49) == 0) lane_en = NL'($urandom);
                if ($urandom_range(0, 99) == 0) begin
                    cfg_f = 8'($urandom_range(0, 12));
                    cfg_len = 8'($urandom_range(0, 3));
                end
                frame(fr_sn, fr_fc);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
